flash_boot_loader: RTL and testbench

// - Parametrised SPI-flash-to-ramio copy engine: reads FlashTransferBytes from flash offset

---
 rtl/flash_boot_loader_pkg.sv | 27 ++
 rtl/flash_boot_loader_spi_shift_engine.sv | 65 ++++++
 rtl/flash_boot_loader.sv | 210 +++++++++++++++++++++
 tb/tb_flash_boot_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_boot_loader_pkg.sv
// Shared types and SPI constants for the flash-to-ramio boot copy engine.
package flash_boot_loader_pkg;

  typedef enum logic [3:0] {
    Init,
    Idle,
    Command,
    Address,
    Dummy,
    ReadData,
    StartWrite,
    Write,
    Finish
  } state_e;

  localparam logic [7:0] CmdRead     = 8'h03;
  localparam logic [7:0] CmdFastRead = 8'h0B;
  localparam int unsigned DummyBits  = 8;
  localparam int unsigned BitCntW    = 6;
  localparam int unsigned WordW      = 32;

  // Flash streams the lowest-addressed byte first; ramio wants it in the low lane.
  function automatic logic [WordW-1:0] byte_swap(input logic [WordW-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_boot_loader_spi_shift_engine.sv
// SPI mode-0 shift engine: divided clock, MSB-first shift out on mosi, shift in on miso.
module flash_boot_loader_spi_shift_engine #(
  parameter int unsigned ClockDivider = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       load,
  input  logic [flash_boot_loader_pkg::WordW-1:0]    tx_data,
  input  logic [flash_boot_loader_pkg::BitCntW-1:0]  bit_count,
  input  logic                                       hold,
  input  logic                                       miso,
  output logic                                       sclk,
  output logic                                       mosi,
  output logic [flash_boot_loader_pkg::WordW-1:0]    rx_data,
  output logic                                       done_c
);
  import flash_boot_loader_pkg::*;

  localparam int unsigned DivW = (ClockDivider > 1) ? $clog2(ClockDivider) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClockDivider - 1);

  logic               active;
  logic [DivW-1:0]    div_cnt;
  logic [BitCntW-1:0] bits_left;
  logic [WordW-1:0]   shreg;
  logic               half_end;

  assign half_end = (div_cnt == DivLast);
  assign mosi     = shreg[WordW-1];
  // Fires on the falling-edge cycle of the last bit so the next transfer can load seamlessly.
  assign done_c   = active && !hold && sclk && half_end && (bits_left == BitCntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      sclk      <= 1'b0;
    end else if (load) begin
      active    <= 1'b1;
      div_cnt   <= '0;
      bits_left <= bit_count;
      shreg     <= tx_data;
      sclk      <= 1'b0;
    end else if (active && !hold) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk    <= 1'b1;
          rx_data <= {rx_data[WordW-2:0], miso};
        end else begin
          sclk      <= 1'b0;
          shreg     <= {shreg[WordW-2:0], 1'b0};
          bits_left <= bits_left - BitCntW'(1);
          if (bits_left == BitCntW'(1)) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Copies a block of SPI flash into ramio as 32-bit words, then pulses done.
module flash_boot_loader #(
  parameter int unsigned StartupWaitCycles  = 10,
  parameter logic [31:0] FlashTransferBytes = 32'h0010_0000,
  parameter logic [23:0] FlashStartAddress  = 24'h00_0000,
  parameter logic [31:0] RamStartAddress    = 32'h0000_0000,
  parameter int unsigned ClockDivider       = 1,
  parameter bit          FastRead           = 1'b0,
  parameter bit          AutoStart          = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ramio_enable,
  output logic [2:0]  ramio_read_type,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy,
  output logic        flash_clk,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_cs
);
  import flash_boot_loader_pkg::*;

  localparam logic [31:0] WordCount = FlashTransferBytes >> 2;
  localparam logic [31:0] LastWord  = WordCount - 32'd1;
  localparam logic [7:0]  ReadCmd   = FastRead ? CmdFastRead : CmdRead;

  if (FlashTransferBytes == 32'd0 || FlashTransferBytes[1:0] != 2'b00) begin : g_bad_size
    $error("FlashTransferBytes must be non-zero and a multiple of 4");
  end
  if (RamStartAddress[1:0] != 2'b00) begin : g_bad_ram_addr
    $error("RamStartAddress must be 4-byte aligned");
  end
  if (ClockDivider == 0) begin : g_bad_div
    $error("ClockDivider must be at least 1");
  end

  state_e              state, state_nxt;
  logic [31:0]         init_cnt, init_cnt_nxt;
  logic [31:0]         word_cnt, word_cnt_nxt;
  logic [31:0]         wr_addr, wr_addr_nxt;
  logic                busy_nxt, done_nxt, flash_cs_nxt, enable_nxt;
  logic [1:0]          write_type_nxt;
  logic [31:0]         address_nxt, data_nxt;
  logic                kick;
  logic                spi_load_c;
  logic [WordW-1:0]    spi_tx_c;
  logic [BitCntW-1:0]  spi_bits_c;
  logic                spi_done_c;
  logic [WordW-1:0]    spi_rx;

  assign ramio_read_type = 3'b000;

  flash_boot_loader_spi_shift_engine #(
    .ClockDivider (ClockDivider)
  ) u_spi_shift_engine (
    .clk       (clk),
    .rst       (rst),
    .load      (spi_load_c),
    .tx_data   (spi_tx_c),
    .bit_count (spi_bits_c),
    .hold      (1'b0),
    .miso      (flash_miso),
    .sclk      (flash_clk),
    .mosi      (flash_mosi),
    .rx_data   (spi_rx),
    .done_c    (spi_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= Init;
      init_cnt         <= '0;
      word_cnt         <= '0;
      wr_addr          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      flash_cs         <= 1'b1;
      ramio_enable     <= 1'b0;
      ramio_write_type <= 2'b00;
      ramio_address    <= '0;
      ramio_data_in    <= '0;
    end else begin
      state            <= state_nxt;
      init_cnt         <= init_cnt_nxt;
      word_cnt         <= word_cnt_nxt;
      wr_addr          <= wr_addr_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      flash_cs         <= flash_cs_nxt;
      ramio_enable     <= enable_nxt;
      ramio_write_type <= write_type_nxt;
      ramio_address    <= address_nxt;
      ramio_data_in    <= data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    init_cnt_nxt   = init_cnt;
    word_cnt_nxt   = word_cnt;
    wr_addr_nxt    = wr_addr;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    flash_cs_nxt   = flash_cs;
    enable_nxt     = ramio_enable;
    write_type_nxt = ramio_write_type;
    address_nxt    = ramio_address;
    data_nxt       = ramio_data_in;
    kick           = 1'b0;
    spi_load_c     = 1'b0;
    spi_tx_c       = '0;
    spi_bits_c     = '0;

    unique case (state)
      Init: begin
        if (init_cnt + 32'd1 >= StartupWaitCycles) begin
          if (AutoStart) kick = 1'b1;
          else           state_nxt = Idle;
        end else begin
          init_cnt_nxt = init_cnt + 32'd1;
        end
      end
      Idle: begin
        if (start) kick = 1'b1;
      end
      Command: begin
        if (spi_done_c) begin
          state_nxt  = Address;
          spi_load_c = 1'b1;
          spi_tx_c   = {FlashStartAddress, 8'h00};
          spi_bits_c = BitCntW'(24);
        end
      end
      Address: begin
        if (spi_done_c) begin
          spi_load_c = 1'b1;
          if (FastRead) begin
            state_nxt  = Dummy;
            spi_bits_c = BitCntW'(DummyBits);
          end else begin
            state_nxt  = ReadData;
            spi_bits_c = BitCntW'(32);
          end
        end
      end
      Dummy: begin
        if (spi_done_c) begin
          state_nxt  = ReadData;
          spi_load_c = 1'b1;
          spi_bits_c = BitCntW'(32);
        end
      end
      ReadData: begin
        if (spi_done_c) state_nxt = StartWrite;
      end
      StartWrite: begin
        if (!ramio_busy) begin
          state_nxt      = Write;
          enable_nxt     = 1'b1;
          write_type_nxt = 2'b11;
          address_nxt    = wr_addr;
          data_nxt       = byte_swap(spi_rx);
        end
      end
      Write: begin
        // Flash clock stays parked low until the write completes, so no bit is lost.
        if (!ramio_busy) begin
          enable_nxt     = 1'b0;
          write_type_nxt = 2'b00;
          if (word_cnt == LastWord) begin
            state_nxt    = Finish;
            flash_cs_nxt = 1'b1;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            state_nxt    = ReadData;
            word_cnt_nxt = word_cnt + 32'd1;
            wr_addr_nxt  = wr_addr + 32'd4;
            spi_load_c   = 1'b1;
            spi_bits_c   = BitCntW'(32);
          end
        end
      end
      Finish: begin
        state_nxt = Idle;
      end
      default: begin
        state_nxt = Init;
      end
    endcase

    if (kick) begin
      state_nxt    = Command;
      flash_cs_nxt = 1'b0;
      busy_nxt     = 1'b1;
      word_cnt_nxt = '0;
      wr_addr_nxt  = RamStartAddress;
      spi_load_c   = 1'b1;
      spi_tx_c     = {ReadCmd, 24'h00_0000};
      spi_bits_c   = BitCntW'(8);
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench: two loader instances (default read, fast read with slow clock) against a flash model.
`timescale 1ns/1ps
module tb_flash_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, start0, start1, rbusy0;
  int   tests = 0;
  int   fails = 0;
  int   bad, base, dbase, edges_after;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit Fast = (g == 1);
    localparam int HdrBits = Fast ? 40 : 32;

    logic        busy, done, ramio_enable, flash_clk, flash_mosi, flash_cs, rb;
    logic        miso = 1'b0;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] address, data;
    logic [39:0] hdr = '0;
    logic [23:0] faddr, ba;
    logic [31:0] wa [16];
    logic [31:0] wd [16];
    int fbits = 0, idx = 0, n_wr = 0, n_done = 0, fedges_s = 0, cyc = 0, run = 0;
    int t_first = 0, t_hdr = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    logic fclk_q = 1'b0;

    assign rb    = (g == 0) ? rbusy0 : 1'b0;
    assign faddr = Fast ? hdr[31:8] : hdr[23:0];

    flash_boot_loader #(
      .StartupWaitCycles  (10),
      .FlashTransferBytes (32'd8),
      .FlashStartAddress  (Fast ? 24'h000100 : 24'h000000),
      .RamStartAddress    (Fast ? 32'h0000_1000 : 32'h0000_0000),
      .ClockDivider       (Fast ? 3 : 1),
      .FastRead           (Fast),
      .AutoStart          (!Fast)
    ) u_dut (
      .clk              (clk),
      .rst              ((g == 0) ? rst0 : rst1),
      .start            ((g == 0) ? start0 : start1),
      .busy             (busy),
      .done             (done),
      .ramio_enable     (ramio_enable),
      .ramio_read_type  (read_type),
      .ramio_write_type (write_type),
      .ramio_address    (address),
      .ramio_data_in    (data),
      .ramio_busy       (rb),
      .flash_clk        (flash_clk),
      .flash_miso       (miso),
      .flash_mosi       (flash_mosi),
      .flash_cs         (flash_cs)
    );

    // Flash model: captures command/address/dummy, then serves byte value = address[7:0].
    always @(posedge flash_clk or posedge flash_cs) begin
      if (flash_cs) fbits <= 0;
      else begin
        if (fbits < HdrBits) hdr <= {hdr[38:0], flash_mosi};
        fbits <= fbits + 1;
      end
    end

    always @(negedge flash_clk) begin
      if (!flash_cs && fbits >= HdrBits) begin
        idx = fbits - HdrBits;
        ba  = faddr + 24'(idx / 8);
        miso <= ba[7 - (idx % 8)];
      end
    end

    // Write log, done count and flash clock level-run measurement.
    always @(posedge clk) begin
      cyc    <= cyc + 1;
      fclk_q <= flash_clk;
      if (ramio_enable && !rb && write_type == 2'b11) begin
        wa[n_wr % 16] <= address;
        wd[n_wr % 16] <= data;
        n_wr <= n_wr + 1;
      end
      if (done) n_done <= n_done + 1;
      if (flash_clk == fclk_q) run <= run + 1;
      else begin
        run <= 1;
        if (fclk_q && fedges_s <= 40) begin
          if (run < hi_min) hi_min <= run;
          if (run > hi_max) hi_max <= run;
        end
        if (flash_clk) begin
          fedges_s <= fedges_s + 1;
          if (fedges_s == 0)  t_first <= cyc;
          if (fedges_s == 32) t_hdr <= cyc;
          if (fedges_s >= 1 && fedges_s < 40) begin
            if (run < lo_min) lo_min <= run;
            if (run > lo_max) lo_max <= run;
          end
        end
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0; rbusy0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs",    32'(g_dut[0].flash_cs), 32'd1);
    check("rst_ctrl",  32'({g_dut[0].busy, g_dut[0].done, g_dut[0].ramio_enable,
                            g_dut[0].flash_clk, g_dut[0].flash_mosi}), 32'd0);
    check("rst_types", 32'({g_dut[0].read_type, g_dut[0].write_type}), 32'd0);
    check("rst_addr",  g_dut[0].address, 32'd0);
    check("rst_data",  g_dut[0].data, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Default read, first word, then backpressure on the second word.
    for (int i = 0; i < 400 && g_dut[0].n_wr < 1; i++) @(negedge clk);
    rbusy0 = 1'b1;
    check("t1_wr_count", 32'(g_dut[0].n_wr), 32'd1);
    check("t1_header",   g_dut[0].hdr[31:0], 32'h0300_0000);
    check("t1_addr0",    g_dut[0].wa[0], 32'h0000_0000);
    check("t1_data0",    g_dut[0].wd[0], 32'h0302_0100);
    repeat (80) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (g_dut[0].flash_clk || g_dut[0].flash_cs || g_dut[0].ramio_enable) bad++;
      @(negedge clk);
    end
    check("t4_stall_bad_cycles", 32'(bad), 32'd0);
    rbusy0 = 1'b0;
    for (int i = 0; i < 20 && g_dut[0].n_wr < 2; i++) @(negedge clk);
    check("t1_addr1", g_dut[0].wa[1], 32'h0000_0004);
    check("t4_data1", g_dut[0].wd[1], 32'h0706_0504);
    for (int i = 0; i < 20 && g_dut[0].n_done < 1; i++) @(negedge clk);
    @(negedge clk);
    check("t1_done_count", 32'(g_dut[0].n_done), 32'd1);
    check("t1_idle_state", 32'({g_dut[0].busy, g_dut[0].flash_cs}), 32'b01);

    // Reset in the middle of the first data word, then a clean re-run.
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    for (int i = 0; i < 50 && g_dut[0].flash_cs; i++) @(negedge clk);
    repeat (74) @(negedge clk);
    rst0 = 1'b1;
    #1;
    check("t6_async_ctrl", 32'({g_dut[0].flash_cs, g_dut[0].ramio_enable, g_dut[0].busy,
                               g_dut[0].flash_clk}), 32'b1000);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    base  = g_dut[0].n_wr;
    dbase = g_dut[0].n_done;
    for (int i = 0; i < 500 && g_dut[0].n_done == dbase; i++) @(negedge clk);
    check("t6_done",   32'(g_dut[0].n_done - dbase), 32'd1);
    check("t6_writes", 32'(g_dut[0].n_wr - base), 32'd2);
    check("t6_addr0",  g_dut[0].wa[base % 16], 32'h0000_0000);
    check("t6_data0",  g_dut[0].wd[base % 16], 32'h0302_0100);
    check("t6_data1",  g_dut[0].wd[(base + 1) % 16], 32'h0706_0504);

    // Manual start, fast read, divider 3.
    check("t5_no_activity", 32'({g_dut[1].flash_cs, 8'(g_dut[1].fedges_s), g_dut[1].busy}),
          32'({1'b1, 8'd0, 1'b0}));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t5_busy", 32'(g_dut[1].busy), 32'd1);
    repeat (20) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 2000 && !g_dut[1].done; i++) @(negedge clk);
    check("t5_done_seen", 32'(g_dut[1].done), 32'd1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t5_done_one_cycle", 32'(g_dut[1].done), 32'd0);
    edges_after = g_dut[1].fedges_s;
    repeat (50) @(negedge clk);
    check("t5_start_at_done_ignored", 32'({g_dut[1].busy, g_dut[1].flash_cs}), 32'b01);
    check("t5_no_new_edges", 32'(g_dut[1].fedges_s - edges_after), 32'd0);
    check("t5_done_count",   32'(g_dut[1].n_done), 32'd1);
    check("t2_cmd",   32'(g_dut[1].hdr[39:32]), 32'h0B);
    check("t2_addr",  32'(g_dut[1].hdr[31:8]), 32'h00_0100);
    check("t2_dummy", 32'(g_dut[1].hdr[7:0]), 32'h00);
    check("t2_addr0", g_dut[1].wa[0], 32'h0000_1000);
    check("t2_data0", g_dut[1].wd[0], 32'h0302_0100);
    check("t2_addr1", g_dut[1].wa[1], 32'h0000_1004);
    check("t2_data1", g_dut[1].wd[1], 32'h0706_0504);
    check("t3_hdr_cycles", 32'(g_dut[1].t_hdr - g_dut[1].t_first), 32'd192);
    check("t3_high_width", 32'({8'(g_dut[1].hi_min), 8'(g_dut[1].hi_max)}), 32'h0303);
    check("t3_low_width",  32'({8'(g_dut[1].lo_min), 8'(g_dut[1].lo_max)}), 32'h0303);

    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 2000 && g_dut[1].n_done < 2; i++) @(negedge clk);
    check("t5_rerun_done",  32'(g_dut[1].n_done), 32'd2);
    check("t5_rerun_addr0", g_dut[1].wa[2], 32'h0000_1000);
    check("t5_rerun_data0", g_dut[1].wd[2], 32'h0302_0100);
    check("t5_rerun_addr1", g_dut[1].wa[3], 32'h0000_1004);
    check("t5_rerun_data1", g_dut[1].wd[3], 32'h0706_0504);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
